// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with 3-sample majority vote, parity/framing/overrun
// flags and a one-entry valid/ready holding register.
// Ports: clk, reset (async, active-high), rx_pin (async serial in, idle 1),
//   baud_div (tick period - 1), rx_data/rx_valid/rx_ready (held word handshake),
//   parity_err, frame_err (per held word), overrun (sticky), busy (frame active).
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_pin,
    input  logic [15:0]          baud_div,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_DLST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_SLST = BW'(STOP_BITS - 1);
    localparam logic          ODD    = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP
    } state_t;

    state_t               r_state;
    logic                 r_sync1, r_sync2;
    logic [15:0]          r_div_l, r_tcnt;
    logic [SW-1:0]        r_scnt, r_acnt;
    logic                 r_c0, r_c1, r_armed, r_pe, r_fe;
    logic [BW-1:0]        r_bcnt;
    logic [DATA_BITS-1:0] r_shift;

    logic        w_rxs, w_tick, w_bend, w_vote_en, w_vote;
    logic        w_start, w_acc, w_free;
    logic [15:0] w_div;

    assign w_rxs     = r_sync2;
    // Live divisor while idle, frozen copy once a frame has started.
    assign w_div     = (r_state == S_IDLE) ? baud_div : r_div_l;
    // >= keeps the idle counter from running away if baud_div shrinks.
    assign w_tick    = (r_tcnt >= w_div);
    assign w_bend    = w_tick && (r_scnt == S_LAST);
    assign w_vote_en = w_tick && (r_scnt == S_HI) && (r_state != S_IDLE);
    assign w_vote    = (r_c0 & r_c1) | (r_c0 & w_rxs) | (r_c1 & w_rxs);
    assign w_start   = (r_state == S_IDLE) && r_armed && !w_rxs;
    assign w_acc     = rx_valid && rx_ready;
    assign w_free    = !rx_valid || rx_ready;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_pin;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcnt <= '0;
        end else if (w_start || w_tick) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_div_l    <= '0;
            r_scnt     <= '0;
            r_acnt     <= '0;
            r_c0       <= 1'b1;
            r_c1       <= 1'b1;
            r_armed    <= 1'b0;
            r_pe       <= 1'b0;
            r_fe       <= 1'b0;
            r_bcnt     <= '0;
            r_shift    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (w_acc) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
            // Arming: OVERSAMPLE idle-high ticks before a start is trusted.
            if (!w_rxs) begin
                r_armed <= 1'b0;
                r_acnt  <= '0;
            end else if (r_state == S_IDLE && w_tick && !r_armed) begin
                if (r_acnt == S_LAST) r_armed <= 1'b1;
                else                  r_acnt  <= r_acnt + SW'(1);
            end
            if (r_state != S_IDLE && w_tick) begin
                r_scnt <= w_bend ? '0 : r_scnt + SW'(1);
                if (r_scnt == S_LO)  r_c0 <= w_rxs;
                if (r_scnt == S_MID) r_c1 <= w_rxs;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_START;
                        r_div_l <= baud_div;
                        r_scnt  <= '0;
                        r_bcnt  <= '0;
                        r_pe    <= 1'b0;
                        r_fe    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_vote_en && w_vote) begin
                        r_state <= S_IDLE;
                        r_armed <= 1'b0;
                        r_acnt  <= '0;
                    end else if (w_bend) begin
                        r_state <= S_DATA;
                        r_bcnt  <= '0;
                    end
                end
                S_DATA: begin
                    if (w_vote_en)
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    if (w_bend) begin
                        if (r_bcnt == B_DLST) begin
                            r_bcnt  <= '0;
                            r_state <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            r_bcnt <= r_bcnt + BW'(1);
                        end
                    end
                end
                S_PAR: begin
                    if (w_vote_en)
                        r_pe <= (^r_shift) ^ w_vote ^ ODD;
                    if (w_bend) begin
                        r_state <= S_STOP;
                        r_bcnt  <= '0;
                    end
                end
                S_STOP: begin
                    if (w_vote_en) begin
                        if (!w_vote) r_fe <= 1'b1;
                        // Last stop vote: drop to IDLE at once to resync.
                        if (r_bcnt == B_SLST) begin
                            r_state <= S_IDLE;
                            r_armed <= w_vote;
                            if (w_free) begin
                                rx_data    <= r_shift;
                                parity_err <= r_pe;
                                frame_err  <= r_fe | ~w_vote;
                                rx_valid   <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end else if (w_bend) begin
                        r_bcnt <= r_bcnt + BW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed testbench for uart_rx_cfg: four instances cover default 8N1,
// even parity, odd parity and 7-bit/2-stop configurations.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    localparam int BP = 64; // 16 ticks * (baud_div 3 + 1)

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  pin = 4'hF;
    logic [15:0] baud_div = 16'd3;
    logic        rx_ready = 1'b1;

    logic [7:0] d0, d1, d2;
    logic [6:0] d3;
    logic v0, v1, v2, v3;
    logic pe0, pe1, pe2, pe3;
    logic fe0, fe1, fe2, fe3;
    logic ov0, ov1, ov2, ov3;
    logic bz0, bz1, bz2, bz3;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_start = 0;
    int vcnt [4];
    int vfirst [4];
    logic [8:0] ldata [4];
    logic lpe [4];
    logic lfe [4];
    logic [8:0] dd [4];
    logic [3:0] vv, pp, ff;

    uart_rx_cfg u0 (
        .clk(clk), .reset(reset), .rx_pin(pin[0]), .baud_div(baud_div),
        .rx_data(d0), .rx_valid(v0), .rx_ready(rx_ready),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(bz0));
    uart_rx_cfg #(.PARITY(2)) u1 (
        .clk(clk), .reset(reset), .rx_pin(pin[1]), .baud_div(baud_div),
        .rx_data(d1), .rx_valid(v1), .rx_ready(rx_ready),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(bz1));
    uart_rx_cfg #(.PARITY(1)) u2 (
        .clk(clk), .reset(reset), .rx_pin(pin[2]), .baud_div(baud_div),
        .rx_data(d2), .rx_valid(v2), .rx_ready(rx_ready),
        .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .busy(bz2));
    uart_rx_cfg #(.DATA_BITS(7), .STOP_BITS(2)) u3 (
        .clk(clk), .reset(reset), .rx_pin(pin[3]), .baud_div(baud_div),
        .rx_data(d3), .rx_valid(v3), .rx_ready(rx_ready),
        .parity_err(pe3), .frame_err(fe3), .overrun(ov3), .busy(bz3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        dd[0] = {1'b0, d0};
        dd[1] = {1'b0, d1};
        dd[2] = {1'b0, d2};
        dd[3] = {2'b0, d3};
        vv = {v3, v2, v1, v0};
        pp = {pe3, pe2, pe1, pe0};
        ff = {fe3, fe2, fe1, fe0};
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (vv[k]) begin
                if (vcnt[k] == 0) vfirst[k] = cyc;
                vcnt[k]++;
                ldata[k] = dd[k];
                lpe[k] = pp[k];
                lfe[k] = ff[k];
            end
        end
    end

    // Drive n bits (bit 0 first) on pin d; optionally invert one clock
    // at offset fo inside bit fb.
    task automatic send(input int d, input logic [15:0] bits, input int n,
                        input int fb, input int fo);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < BP; c++) begin
                @(negedge clk);
                if (i == fb && c == fo) pin[d] = ~bits[i];
                else pin[d] = bits[i];
                if (i == 0 && c == 0) t_start = cyc;
            end
        end
        @(negedge clk);
        pin[d] = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (vv !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0000", vv);
        end
        n_cmp++;
        if (d0 !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 00", d0);
        end
        n_cmp++;
        if ({pe0, fe0, ov0} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000", {pe0, fe0, ov0});
        end
        n_cmp++;
        if ({bz3, bz2, bz1, bz0} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %b want 0000", {bz3, bz2, bz1, bz0});
        end
        reset = 1'b0;
        repeat (200) @(negedge clk);
        n_cmp++;
        if (bz0 !== 1'b0 || v0 !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy %b valid %b want 0 0", bz0, v0);
        end
    endtask

    task automatic test_basic_8n1();
        vcnt[0] = 0;
        send(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 2, 36);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (vcnt[0] !== 1) begin
            n_bad++;
            $display("FAIL basic_valid_cycles: got %0d want 1", vcnt[0]);
        end
        n_cmp++;
        if (ldata[0] !== 9'h0A5) begin
            n_bad++;
            $display("FAIL basic_data: got %h want 0a5", ldata[0]);
        end
        n_cmp++;
        if ({lpe[0], lfe[0], ov0} !== 3'b000) begin
            n_bad++;
            $display("FAIL basic_flags: got %b want 000", {lpe[0], lfe[0], ov0});
        end
        n_cmp++;
        if (vfirst[0] !== t_start + 619) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d want %0d",
                     vfirst[0] - t_start, 619);
        end
    endtask

    task automatic test_parity();
        vcnt[1] = 0;
        send(1, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, -1, 0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (vcnt[1] !== 1 || ldata[1] !== 9'h003) begin
            n_bad++;
            $display("FAIL even_p1_data: cnt %0d data %h want 1 003", vcnt[1], ldata[1]);
        end
        n_cmp++;
        if (lpe[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL even_p1_perr: got %b want 1", lpe[1]);
        end
        repeat (20) @(negedge clk);
        vcnt[1] = 0;
        send(1, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, -1, 0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (vcnt[1] !== 1 || ldata[1] !== 9'h003) begin
            n_bad++;
            $display("FAIL even_p0_data: cnt %0d data %h want 1 003", vcnt[1], ldata[1]);
        end
        n_cmp++;
        if (lpe[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL even_p0_perr: got %b want 0", lpe[1]);
        end
        vcnt[2] = 0;
        send(2, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, -1, 0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (vcnt[2] !== 1 || ldata[2] !== 9'h003) begin
            n_bad++;
            $display("FAIL odd_p1_data: cnt %0d data %h want 1 003", vcnt[2], ldata[2]);
        end
        n_cmp++;
        if (lpe[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL odd_p1_perr: got %b want 0", lpe[2]);
        end
    endtask

    task automatic test_framing();
        vcnt[3] = 0;
        send(3, {6'b0, 1'b0, 1'b1, 7'h55, 1'b0}, 10, -1, 0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (vcnt[3] !== 1 || ldata[3] !== 9'h055) begin
            n_bad++;
            $display("FAIL frame_data: cnt %0d data %h want 1 055", vcnt[3], ldata[3]);
        end
        n_cmp++;
        if (lfe[3] !== 1'b1 || lpe[3] !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_ferr: fe %b pe %b want 1 0", lfe[3], lpe[3]);
        end
    endtask

    task automatic test_false_start();
        int t0;
        vcnt[0] = 0;
        @(negedge clk);
        pin[0] = 1'b0;
        t0 = cyc;
        repeat (16) @(negedge clk);
        pin[0] = 1'b1;
        while (cyc < t0 + 42) @(negedge clk);
        n_cmp++;
        if (bz0 !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_busy_before_vote: got %b want 1", bz0);
        end
        @(negedge clk);
        n_cmp++;
        if (bz0 !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_busy_after_vote: got %b want 0", bz0);
        end
        repeat (200) @(negedge clk);
        n_cmp++;
        if (vcnt[0] !== 0) begin
            n_bad++;
            $display("FAIL glitch_no_output: got %0d want 0", vcnt[0]);
        end
        send(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, -1, 0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (vcnt[0] !== 1 || ldata[0] !== 9'h03C || lfe[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_next_frame: cnt %0d data %h fe %b want 1 03c 0",
                     vcnt[0], ldata[0], lfe[0]);
        end
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        repeat (20) @(negedge clk);
        send(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, -1, 0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (v0 !== 1'b1 || d0 !== 8'h11 || ov0 !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_first: valid %b data %h ovr %b want 1 11 0", v0, d0, ov0);
        end
        repeat (20) @(negedge clk);
        send(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, -1, 0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (v0 !== 1'b1 || d0 !== 8'h11) begin
            n_bad++;
            $display("FAIL ovr_held: valid %b data %h want 1 11", v0, d0);
        end
        n_cmp++;
        if (ov0 !== 1'b1) begin
            n_bad++;
            $display("FAIL ovr_flag: got %b want 1", ov0);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        n_cmp++;
        if (v0 !== 1'b0 || ov0 !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_accept: valid %b ovr %b want 0 0", v0, ov0);
        end
        rx_ready = 1'b1;
    endtask

    task automatic test_reset_midframe();
        vcnt[0] = 0;
        repeat (20) @(negedge clk);
        @(negedge clk);
        pin[0] = 1'b0;
        repeat (3 * BP) @(negedge clk);
        n_cmp++;
        if (bz0 !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_busy: got %b want 1", bz0);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2 * BP) @(negedge clk);
        n_cmp++;
        if (bz0 !== 1'b0 || v0 !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_low_line: busy %b valid %b want 0 0", bz0, v0);
        end
        pin[0] = 1'b1;
        repeat (300) @(negedge clk);
        n_cmp++;
        if (vcnt[0] !== 0 || bz0 !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_no_frame: cnt %0d busy %b want 0 0", vcnt[0], bz0);
        end
        send(0, {6'b0, 1'b1, 8'h81, 1'b0}, 10, -1, 0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (vcnt[0] !== 1 || ldata[0] !== 9'h081) begin
            n_bad++;
            $display("FAIL rst_next_frame: cnt %0d data %h want 1 081", vcnt[0], ldata[0]);
        end
        n_cmp++;
        if ({lpe[0], lfe[0], ov0} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_next_flags: got %b want 000", {lpe[0], lfe[0], ov0});
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity();
        test_framing();
        test_false_start();
        test_overrun();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
